// File: rtl/encoder8to3_stream_if.sv
// Valid/ready stream bundle for the 8-to-3 streaming encoder:
// 8-bit line vectors in, 3-bit indices out.
interface encoder8to3_stream_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_d;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_code;
    logic       out_last;

    modport master (
        output in_valid,
        output in_d,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_code,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_d,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_code,
        output out_last
    );
endinterface

// File: rtl/encoder8to3_stream.sv
// Streaming 8-to-3 encoder: splits a multi-hot vector into one
// binary index per output beat, in priority order.
module encoder8to3_stream #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic clk,
    input  logic rst,
    encoder8to3_stream_if.slave bus,
    output logic zero_drop,
    output logic busy
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [7:0] pending;
    logic [7:0] pending_n;
    logic       zero_drop_n;
    logic [2:0] idx;
    logic [7:0] clr_mask;
    logic       single;
    logic       in_fire;
    logic       out_fire;

    // Later loop iterations win, so the scan direction sets priority.
    always_comb begin
        idx = 3'd0;
        if (LSB_FIRST) begin
            for (int i = 7; i >= 0; i--) begin
                if (pending[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (pending[i]) idx = 3'(i);
            end
        end
    end

    assign clr_mask = 8'b1 << idx;
    assign single   = (pending != 8'd0)
                   && ((pending & (pending - 8'd1)) == 8'd0);

    assign busy          = (state == EMIT);
    assign bus.out_valid = busy;
    assign bus.out_code  = idx;
    assign bus.out_last  = busy && single;
    assign bus.in_ready  = busy ? (bus.out_ready && single) : 1'b1;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= 8'd0;
            zero_drop <= 1'b0;
        end else begin
            state     <= state_n;
            pending   <= pending_n;
            zero_drop <= zero_drop_n;
        end
    end

    always_comb begin
        state_n     = state;
        pending_n   = pending;
        zero_drop_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_fire) begin
                    if (bus.in_d != 8'd0) begin
                        pending_n = bus.in_d;
                        state_n   = EMIT;
                    end else begin
                        zero_drop_n = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_fire) begin
                    pending_n = pending & ~clr_mask;
                    if (single) begin
                        state_n = IDLE;
                        // Reload on the last beat so back-to-back vectors see no bubble.
                        if (in_fire) begin
                            if (bus.in_d != 8'd0) begin
                                pending_n = bus.in_d;
                                state_n   = EMIT;
                            end else begin
                                zero_drop_n = 1'b1;
                            end
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_encoder8to3_stream.sv
// Bench for encoder8to3_stream: both priority orders side by side,
// checked against a queue-of-indices reference model.
module tb_encoder8to3_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic zd1, bz1, zd0, bz0;

    encoder8to3_stream_if b1 ();
    encoder8to3_stream_if b0 ();

    encoder8to3_stream #(.LSB_FIRST(1'b1)) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(b1.slave),
        .zero_drop(zd1),
        .busy(bz1)
    );

    encoder8to3_stream #(.LSB_FIRST(1'b0)) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(b0.slave),
        .zero_drop(zd0),
        .busy(bz0)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    // q[m]: indices still to be emitted for the current vector; m = LSB_FIRST
    int q[2][$];
    bit zd[2];

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] d,
                         input logic ordy);
        b1.in_valid  = iv;
        b1.in_d      = d;
        b1.out_ready = ordy;
        b0.in_valid  = iv;
        b0.in_d      = d;
        b0.out_ready = ordy;
    endtask

    task automatic check_all(input string tag, input logic ordy);
        logic       v, l, r, z, b;
        logic [2:0] c;
        logic       ev, el, er;
        logic [2:0] ec;
        for (int m = 0; m < 2; m++) begin
            if (m == 1) begin
                v = b1.out_valid; c = b1.out_code; l = b1.out_last;
                r = b1.in_ready;  z = zd1;         b = bz1;
            end else begin
                v = b0.out_valid; c = b0.out_code; l = b0.out_last;
                r = b0.in_ready;  z = zd0;         b = bz0;
            end
            ev = (q[m].size() > 0);
            ec = ev ? 3'(q[m][0]) : 3'd0;
            el = (q[m].size() == 1);
            er = (q[m].size() == 0) || (ordy && q[m].size() == 1);
            chk($sformatf("%s.lsb%0d.out_valid", tag, m), {7'd0, v}, {7'd0, ev});
            chk($sformatf("%s.lsb%0d.out_code", tag, m), {5'd0, c}, {5'd0, ec});
            chk($sformatf("%s.lsb%0d.out_last", tag, m), {7'd0, l}, {7'd0, el});
            chk($sformatf("%s.lsb%0d.in_ready", tag, m), {7'd0, r}, {7'd0, er});
            chk($sformatf("%s.lsb%0d.busy", tag, m), {7'd0, b}, {7'd0, ev});
            chk($sformatf("%s.lsb%0d.zero_drop", tag, m), {7'd0, z}, {7'd0, zd[m]});
        end
    endtask

    // Entered at a falling edge; returns at the next falling edge.
    task automatic step(input logic iv, input logic [7:0] d,
                        input logic ordy, input string tag);
        bit ofire[2];
        bit ifire[2];
        drive(iv, d, ordy);
        #1;
        check_all(tag, ordy);
        for (int m = 0; m < 2; m++) begin
            ofire[m] = (q[m].size() > 0) && ordy;
            ifire[m] = iv && ((q[m].size() == 0)
                           || (ordy && q[m].size() == 1));
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            zd[m] = 1'b0;
            if (ofire[m]) void'(q[m].pop_front());
            if (ifire[m]) begin
                if (d == 8'd0) begin
                    zd[m] = 1'b1;
                end else if (m == 1) begin
                    for (int i = 0; i < 8; i++)
                        if (d[i]) q[m].push_back(i);
                end else begin
                    for (int i = 7; i >= 0; i--)
                        if (d[i]) q[m].push_back(i);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] rd;
        drive(1'b0, 8'd0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_all("reset", 1'b0);
        @(negedge clk);

        step(1'b1, 8'h20, 1'b1, "t20_acc");
        #1;
        chk("t20_code5", {5'd0, b1.out_code}, 8'd5);
        chk("t20_last", {7'd0, b1.out_last}, 8'd1);
        step(1'b0, 8'h00, 1'b1, "t20_beat");
        step(1'b0, 8'h00, 1'b1, "t20_idle");

        step(1'b1, 8'hA5, 1'b1, "tA5_acc");
        #1;
        chk("tA5_first_lsb", {5'd0, b1.out_code}, 8'd0);
        chk("tA5_first_msb", {5'd0, b0.out_code}, 8'd7);
        repeat (4) step(1'b0, 8'h00, 1'b1, "tA5_beat");
        step(1'b0, 8'h00, 1'b1, "tA5_idle");

        step(1'b1, 8'h0C, 1'b0, "t0C_acc");
        repeat (3) step(1'b0, 8'h00, 1'b0, "t0C_hold");
        repeat (3) step(1'b0, 8'h00, 1'b1, "t0C_rel");

        step(1'b1, 8'h81, 1'b1, "t81_acc");
        step(1'b1, 8'h10, 1'b1, "t81_b0");
        step(1'b1, 8'h10, 1'b1, "t81_last");
        #1;
        chk("t10_code4", {5'd0, b1.out_code}, 8'd4);
        chk("t10_busy", {7'd0, bz1}, 8'd1);
        step(1'b0, 8'h00, 1'b1, "t10_beat");
        step(1'b0, 8'h00, 1'b1, "t10_idle");

        step(1'b1, 8'h00, 1'b1, "tz_acc");
        #1;
        chk("tz_pulse", {7'd0, zd1}, 8'd1);
        step(1'b0, 8'h00, 1'b1, "tz_pulse");
        step(1'b0, 8'h00, 1'b1, "tz_after");
        step(1'b1, 8'h02, 1'b1, "t02_acc");
        step(1'b1, 8'h00, 1'b1, "t02_lastz");
        step(1'b0, 8'h00, 1'b1, "t02_zd");
        step(1'b0, 8'h00, 1'b1, "t02_idle");

        step(1'b1, 8'hFF, 1'b1, "tFF_acc");
        repeat (3) step(1'b0, 8'h00, 1'b1, "tFF_beat");
        drive(1'b0, 8'h00, 1'b1);
        rst = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            q[m].delete();
            zd[m] = 1'b0;
        end
        check_all("rst_mid", 1'b1);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h40, 1'b1, "t40_acc");
        #1;
        chk("t40_code6", {5'd0, b1.out_code}, 8'd6);
        step(1'b0, 8'h00, 1'b1, "t40_beat");
        step(1'b0, 8'h00, 1'b1, "t40_idle");

        for (int n = 0; n < 500; n++) begin
            rd = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            step(1'($urandom_range(0, 1)), rd,
                 ($urandom_range(0, 9) < 7), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
